// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, with one-cycle handling of divide-by-zero and overflow.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             kill,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic                   neg_q, neg_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   is_div, a_signed, b_signed, sign_a, sign_b, res_neg;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic                   special;
    logic [WIDTH-1:0]       special_val;

    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         rem_sh;
    logic [WIDTH:0]         div_diff;
    logic [2*WIDTH-1:0]     mul_next, div_next, iter_next, fin_full;
    logic [WIDTH-1:0]       fin_rem, fin_result;

    // Operand decode for a new op: magnitudes, result sign and the non-iterating cases.
    always_comb begin
        is_div      = Funct3[2];
        a_signed    = is_div ? ~Funct3[0] : (Funct3[1:0] == 2'b01 || Funct3[1:0] == 2'b10);
        b_signed    = is_div ? ~Funct3[0] : (Funct3[1:0] == 2'b01);
        sign_a      = a_signed & SrcA[WIDTH-1];
        sign_b      = b_signed & SrcB[WIDTH-1];
        mag_a       = sign_a ? -SrcA : SrcA;
        mag_b       = sign_b ? -SrcB : SrcB;
        res_neg     = (is_div && Funct3[1]) ? sign_a : (sign_a ^ sign_b);
        special     = 1'b0;
        special_val = '0;
        if (is_div && SrcB == '0) begin
            special     = 1'b1;
            special_val = Funct3[1] ? SrcA : '1;
        end else if (is_div && !Funct3[0] && SrcA == MIN_NEG && SrcB == '1) begin
            special     = 1'b1;
            special_val = Funct3[1] ? '0 : SrcA;
        end
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = rem_sh - {1'b0, opb_q};
        div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        iter_next = op_q[2] ? div_next : mul_next;
        fin_full  = neg_q ? -iter_next : iter_next;
        fin_rem   = neg_q ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000, 3'b100, 3'b101: fin_result = fin_full[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_result = fin_full[2*WIDTH-1:WIDTH];
            default:                fin_result = fin_rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d  = Funct3;
                    cnt_d = '0;
                    opb_d = mag_b;
                    acc_d = {{WIDTH{1'b0}}, mag_a};
                    neg_d = res_neg;
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = special_val;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                acc_d = iter_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_DONE;
                    result_d = fin_result;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flush discards the op in flight, including a result about to be written.
        if (kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        busy_d = (state_d == S_BUSY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) && start && !kill) || (state_q == S_BUSY);
    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: arithmetic results,
// latency, stall profile, special cases, kill and mid-operation reset.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        kill;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] Result;

    int vectors = 0;
    int miscompares = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .kill   (kill),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one M op, hold start while stalled, and check result, latency and stall profile.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat);
        int          lat;
        int          stallCnt;
        logic        got;
        logic        stallAtDone;
        logic [31:0] res;
        lat         = 0;
        got         = 1'b0;
        stallAtDone = 1'b1;
        res         = 'x;
        @(negedge clk);
        Funct3 = op;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        #1;
        stallCnt = stall ? 1 : 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got         = 1'b1;
                lat         = i;
                res         = Result;
                stallAtDone = stall;
                start       = 1'b0;
            end else if (stall) begin
                stallCnt++;
            end
        end
        start = 1'b0;
        checkOutput({tag, " result"}, res, expRes);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " stall cycles"}, 32'(stallCnt), 32'(expLat));
        checkOutput({tag, " stall on done"}, 32'(stallAtDone), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int doneSeen;
        reset  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset Result", Result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus("MUL 7*-3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        applyStimulus("MULHU -1*-1",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        applyStimulus("MULH -1*-1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        applyStimulus("MULHSU -1*2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        applyStimulus("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        applyStimulus("REM -7%2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        applyStimulus("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       33);
        applyStimulus("REMU 100%7",     3'b111, 32'd100,      32'd7,        32'd2,        33);
        applyStimulus("DIVU x/0",       3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1);
        applyStimulus("REM 5%0",        3'b110, 32'd5,        32'd0,        32'd5,        1);
        applyStimulus("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        applyStimulus("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

        // Kill on the 10th BUSY cycle; Result must keep the overflow result.
        @(negedge clk);
        Funct3 = 3'b000;
        SrcA   = 32'h1234;
        SrcB   = 32'd5;
        start  = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("kill busy before", 32'(busy), 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill  = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("kill busy after", 32'(busy), 32'd0);
        checkOutput("kill stall after", 32'(stall), 32'd0);
        checkOutput("kill Result held", Result, 32'h80000000);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("kill no done", 32'(doneSeen), 32'd0);

        // Reset in the middle of a second operation.
        Funct3 = 3'b101;
        SrcA   = 32'd100;
        SrcB   = 32'd7;
        start  = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("reset-mid busy before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("reset-mid busy after", 32'(busy), 32'd0);
        checkOutput("reset-mid Result", Result, 32'h0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("reset-mid no done", 32'(doneSeen), 32'd0);

        applyStimulus("MUL 3*4",        3'b000, 32'd3,        32'd4,        32'd12,       33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
